// File: rtl/data_mem_if.sv
// data_mem_if: data-memory request/response bundle between the core and its responder
// master = core side (drives request/we_re/mask/address/store_data)
// slave  = responder side (drives valid/load_data/busy, plus err when DATA_MEM_RESP_ERR_EN is defined)
interface data_mem_if;
  logic        request;
  logic        we_re;
  logic [3:0]  mask;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        valid;
  logic [31:0] load_data;
  logic        busy;
`ifdef DATA_MEM_RESP_ERR_EN
  logic        err;
  modport master (output request, we_re, mask, address, store_data, input valid, load_data, busy, err);
  modport slave  (input request, we_re, mask, address, store_data, output valid, load_data, busy, err);
`else
  modport master (output request, we_re, mask, address, store_data, input valid, load_data, busy);
  modport slave  (input request, we_re, mask, address, store_data, output valid, load_data, busy);
`endif
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM answering core load/store requests after LATENCY wait cycles
// ports: clk, rst (sync, active-low), bus (data_mem_if.slave)
// optional macro DATA_MEM_RESP_ERR_EN adds bus.err for out-of-range or misaligned accesses
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 10
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t              state, next;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   idx, rd_idx;
  logic                we_q, drop_q, drop, mis, oor, rd_zero;
  logic [3:0]          mask_q;
  logic [31:0]         data_q, ld;
  logic [31:0]         mem [DEPTH];
  assign oor = (bus.address >> (ADDR_W + 2)) != 32'd0;
`ifdef DATA_MEM_RESP_ERR_EN
  logic [1:0] low;
  assign low = bus.mask[0] ? 2'd0 : bus.mask[1] ? 2'd1 : bus.mask[2] ? 2'd2 : 2'd3;
  assign mis = !(bus.mask inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})
               || bus.address[1:0] != low;
  assign bus.err = state == RESP && drop_q;
`else
  logic unused_lsb;
  assign unused_lsb = &{1'b0, bus.address[1:0]};
  assign mis = 1'b0;
`endif
  assign drop = oor | mis;
  // RAM is read on the edge entering RESP; from IDLE (LATENCY=0) the live inputs are still the source
  assign rd_idx  = state == IDLE ? bus.address[ADDR_W+1:2] : idx;
  assign rd_zero = state == IDLE ? (bus.we_re | drop) : (we_q | drop_q);
  always_comb begin
    next = state == IDLE ? (bus.request ? (LATENCY > 0 ? WAIT : RESP) : IDLE) :
           state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      ld    <= '0;
    end else begin
      state <= next;
      if (state == IDLE && bus.request) begin
        idx    <= bus.address[ADDR_W+1:2];
        we_q   <= bus.we_re;
        mask_q <= bus.mask;
        data_q <= bus.store_data;
        drop_q <= drop;
        cnt    <= 4'(LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (next == RESP) ld <= rd_zero ? '0 : mem[rd_idx];
    end
  end
  always_ff @(posedge clk) begin
    if (rst && state == RESP && we_q && !drop_q)
      for (int i = 0; i < 4; i++)
        if (mask_q[i]) mem[idx][8*i +: 8] <= data_q[8*i +: 8];
  end
  assign bus.valid     = state == RESP;
  assign bus.busy      = state != IDLE;
  assign bus.load_data = ld;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of data_mem_responder at LATENCY 1, 0 and 3
module tb_data_mem_responder;
  logic        clk = 0;
  logic [2:0]  rst_n, req, we;
  logic [3:0]  msk [3];
  logic [31:0] adr [3], wd [3];
  logic [2:0]  vld, bsy;
  logic [31:0] rdat [3];
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gi
    data_mem_if bus ();
    assign bus.request    = req[g];
    assign bus.we_re      = we[g];
    assign bus.mask       = msk[g];
    assign bus.address    = adr[g];
    assign bus.store_data = wd[g];
    assign vld[g]         = bus.valid;
    assign bsy[g]         = bus.busy;
    assign rdat[g]        = bus.load_data;
    data_mem_responder #(.DEPTH(1024), .LATENCY(g == 0 ? 1 : g == 1 ? 0 : 3), .ADDR_W(10)) dut (
      .clk(clk),
      .rst(rst_n[g]),
      .bus(bus.slave)
    );
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // one handshake: lat counts cycles from the accepting cycle to the valid cycle, bc counts busy cycles
  task automatic xact(input int k, input logic w, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat, output int bc);
    @(negedge clk);
    req[k] = 1; we[k] = w; msk[k] = m; adr[k] = a; wd[k] = d;
    @(posedge clk);
    #1;
    lat = 1;
    bc  = 0;
    while (!vld[k] && lat < 20) begin
      bc += int'(bsy[k]);
      @(posedge clk);
      #1;
      lat++;
    end
    bc += int'(bsy[k]);
    rd = rdat[k];
    req[k] = 0;
    @(posedge clk);
    #1;
    chk("valid_one_cycle", 32'(vld[k]), 0);
    chk("busy_after_resp", 32'(bsy[k]), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd;
    logic [5:0]  pat;
    int          lat, bc, nv;
    rst_n = '0; req = '0; we = '0;
    for (int i = 0; i < 3; i++) begin
      msk[i] = '0; adr[i] = '0; wd[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_valid", 32'(vld[i]), 0);
      chk("reset_busy", 32'(bsy[i]), 0);
      chk("reset_load_data", rdat[i], 0);
    end
    @(negedge clk);
    rst_n = '1;
    xact(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, rd, lat, bc);
    chk("st_latency", 32'(lat), 2);
    chk("st_busy_cycles", 32'(bc), 2);
    chk("st_load_data_zero", rd, 0);
    xact(0, 0, 4'hF, 32'h10, 32'h0, rd, lat, bc);
    chk("ld_latency", 32'(lat), 2);
    chk("ld_busy_cycles", 32'(bc), 2);
    chk("ld_data", rd, 32'hDEADBEEF);
    xact(0, 1, 4'b0100, 32'h12, 32'h00AA0000, rd, lat, bc);
    xact(0, 0, 4'hF, 32'h10, 32'h0, rd, lat, bc);
    chk("byte_store_merge", rd, 32'hDEAABEEF);
    xact(0, 1, 4'hF, 32'h0, 32'h12345678, rd, lat, bc);
    xact(0, 1, 4'h0, 32'h0, 32'hFFFFFFFF, rd, lat, bc);
    chk("mask0_latency", 32'(lat), 2);
    xact(0, 0, 4'hF, 32'h0, 32'h0, rd, lat, bc);
    chk("mask0_unchanged", rd, 32'h12345678);
    xact(0, 0, 4'hF, 32'h1000, 32'h0, rd, lat, bc);
    chk("oor_ld_latency", 32'(lat), 2);
    chk("oor_ld_zero", rd, 0);
    xact(0, 1, 4'hF, 32'h1000, 32'hFFFFFFFF, rd, lat, bc);
    chk("oor_st_latency", 32'(lat), 2);
    xact(0, 0, 4'hF, 32'h0, 32'h0, rd, lat, bc);
    chk("oor_st_dropped", rd, 32'h12345678);
    xact(1, 1, 4'hF, 32'h40, 32'hCAFEF00D, rd, lat, bc);
    chk("lat0_latency", 32'(lat), 1);
    chk("lat0_busy_cycles", 32'(bc), 1);
    @(negedge clk);
    req[1] = 1; we[1] = 0; msk[1] = 4'hF; adr[1] = 32'h40;
    pat = '0;
    nv  = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      pat = {pat[4:0], vld[1]};
      if (vld[1]) begin
        chk("b2b_data", rdat[1], 32'hCAFEF00D);
        nv++;
        if (nv == 3) req[1] = 0;
      end
    end
    chk("b2b_pattern", 32'(pat), 32'b101010);
    xact(2, 1, 4'hF, 32'h20, 32'h11111111, rd, lat, bc);
    chk("lat3_latency", 32'(lat), 4);
    chk("lat3_busy_cycles", 32'(bc), 4);
    @(negedge clk);
    req[2] = 1; we[2] = 1; msk[2] = 4'hF; adr[2] = 32'h20; wd[2] = 32'h22222222;
    @(posedge clk);
    #1;
    req[2] = 0;
    chk("abort_busy_wait", 32'(bsy[2]), 1);
    chk("abort_valid_wait", 32'(vld[2]), 0);
    @(posedge clk);
    #1;
    chk("abort_valid_wait2", 32'(vld[2]), 0);
    @(negedge clk);
    rst_n[2] = 0;
    @(posedge clk);
    #1;
    chk("abort_busy_reset", 32'(bsy[2]), 0);
    chk("abort_valid_reset", 32'(vld[2]), 0);
    @(negedge clk);
    rst_n[2] = 1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("abort_no_valid", 32'(vld[2]), 0);
    end
    xact(2, 0, 4'hF, 32'h20, 32'h0, rd, lat, bc);
    chk("abort_ld_latency", 32'(lat), 4);
    chk("abort_store_dropped", rd, 32'h11111111);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
